// File: rtl/rtos_pkg.sv
// Shared constants and types for the RTOS ready-list block.
package rtos_pkg;

  localparam int unsigned NUM_TASKS_DEF = 16;
  localparam int unsigned NUM_PRIO_DEF  = 8;
  localparam logic [7:0]  IDLE_TASK     = 8'd0;

  typedef enum logic [1:0] {
    OpNop    = 2'b00,
    OpReady  = 2'b01,
    OpBlock  = 2'b10,
    OpSettcb = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StApply   = 2'b01,
    StScan    = 2'b10,
    StPublish = 2'b11
  } rl_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/readylist_scan.sv
// Sequential scan accumulator: sees one task per cycle and tracks the
// highest-priority ready task plus the round-robin successor of the current task.
module readylist_scan
  import rtos_pkg::*;
#(
  parameter int unsigned NUM_TASKS = NUM_TASKS_DEF,
  parameter int unsigned NUM_PRIO  = NUM_PRIO_DEF,
  localparam int unsigned TW = idx_width(NUM_TASKS),
  localparam int unsigned PW = idx_width(NUM_PRIO)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          visit,
  input  logic [TW-1:0] idx,
  input  logic          task_ready,
  input  logic [PW-1:0] task_prio,
  input  logic [7:0]    cur_task,
  input  logic          cur_valid,
  input  logic [PW-1:0] cur_prio,
  output logic [PW-1:0] best_prio,
  output logic [TW-1:0] best_task,
  output logic [7:0]    next_task
);

  logic          first;
  logic          best_found_q, best_found_d;
  logic [PW-1:0] best_prio_q, best_prio_d;
  logic [TW-1:0] best_task_q, best_task_d;
  logic          above_found_q, above_found_d;
  logic [TW-1:0] above_task_q, above_task_d;
  logic          below_found_q, below_found_d;
  logic [TW-1:0] below_task_q, below_task_d;

  always_comb begin
    // Visiting index 0 starts a fresh scan, so prior results are discarded.
    first         = (idx == '0);
    best_found_d  = first ? 1'b0 : best_found_q;
    best_prio_d   = first ? '0 : best_prio_q;
    best_task_d   = first ? '0 : best_task_q;
    above_found_d = first ? 1'b0 : above_found_q;
    above_task_d  = first ? '0 : above_task_q;
    below_found_d = first ? 1'b0 : below_found_q;
    below_task_d  = first ? '0 : below_task_q;
    if (visit && task_ready) begin
      // Strict compare keeps the lowest index on priority ties.
      if (!best_found_d || (task_prio > best_prio_d)) begin
        best_found_d = 1'b1;
        best_prio_d  = task_prio;
        best_task_d  = idx;
      end
      if (cur_valid && (task_prio == cur_prio)) begin
        if ((8'(idx) > cur_task) && !above_found_d) begin
          above_found_d = 1'b1;
          above_task_d  = idx;
        end else if ((8'(idx) < cur_task) && !below_found_d) begin
          below_found_d = 1'b1;
          below_task_d  = idx;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      best_found_q  <= 1'b0;
      best_prio_q   <= '0;
      best_task_q   <= '0;
      above_found_q <= 1'b0;
      above_task_q  <= '0;
      below_found_q <= 1'b0;
      below_task_q  <= '0;
    end else if (visit) begin
      best_found_q  <= best_found_d;
      best_prio_q   <= best_prio_d;
      best_task_q   <= best_task_d;
      above_found_q <= above_found_d;
      above_task_q  <= above_task_d;
      below_found_q <= below_found_d;
      below_task_q  <= below_task_d;
    end
  end

  always_comb begin
    best_prio = best_prio_q;
    best_task = best_task_q;
    if (!cur_valid) begin
      next_task = 8'(best_task_q);
    end else if (above_found_q) begin
      next_task = 8'(above_task_q);
    end else if (below_found_q) begin
      next_task = 8'(below_task_q);
    end else begin
      next_task = cur_task;
    end
  end

endmodule

// File: rtl/ready_list.sv
// RTOS ready list: per-task ready/priority/TCB tables, command FSM and a
// serial scan that publishes the highest-priority and round-robin next task.
module ready_list
  import rtos_pkg::*;
#(
  parameter int unsigned NUM_TASKS = NUM_TASKS_DEF,
  parameter int unsigned NUM_PRIO  = NUM_PRIO_DEF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_task,
  input  logic [5:0]  cmd_prio,
  input  logic [31:0] cmd_data,
  input  logic [7:0]  addrread_in,
  output logic [5:0]  highpriority_out,
  output logic [7:0]  ptr_hpritask_out,
  output logic [7:0]  ptr_nexttask_out,
  output logic [31:0] tcbtask_out,
  output logic        err_out
);

  localparam int unsigned TW = idx_width(NUM_TASKS);
  localparam int unsigned PW = idx_width(NUM_PRIO);
  localparam logic [TW-1:0] IDLE_IDX = IDLE_TASK[TW-1:0];

  rl_state_e state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    cur_q, cur_d;

  cmd_op_e     cmd_op_q;
  logic [7:0]  cmd_task_q;
  logic [5:0]  cmd_prio_q;
  logic [31:0] cmd_data_q;
  logic        accept;

  logic [NUM_TASKS-1:0]         ready_q, ready_d;
  logic [NUM_TASKS-1:0][PW-1:0] prio_q, prio_d;
  logic [NUM_TASKS-1:0][31:0]   tcb_q, tcb_d;

  logic [5:0]  hp_q;
  logic [7:0]  hpt_q, nxt_q;

  logic          cmd_task_oob, cmd_prio_oob, cmd_is_idle, cmd_illegal;
  logic [TW-1:0] cmd_idx;
  logic          cur_in_range, cur_valid;
  logic [TW-1:0] cur_idx;
  logic          rd_in_range;
  logic [TW-1:0] rd_idx;

  logic [PW-1:0] scan_best_prio;
  logic [TW-1:0] scan_best_task;
  logic [7:0]    scan_next_task;

  assign cmd_ready = (state_q == StIdle) && aresetn;
  assign accept    = cmd_valid && cmd_ready;

  // Command legality, evaluated on the latched command during APPLY.
  always_comb begin
    cmd_task_oob = 32'(cmd_task_q) >= NUM_TASKS;
    cmd_prio_oob = 32'(cmd_prio_q) >= NUM_PRIO;
    cmd_is_idle  = (cmd_task_q == IDLE_TASK);
    cmd_idx      = cmd_task_oob ? '0 : cmd_task_q[TW-1:0];
    unique case (cmd_op_q)
      OpReady:  cmd_illegal = cmd_task_oob || cmd_is_idle || cmd_prio_oob;
      OpBlock:  cmd_illegal = cmd_task_oob || cmd_is_idle;
      OpSettcb: cmd_illegal = cmd_task_oob;
      default:  cmd_illegal = 1'b0;
    endcase
  end

  assign err_out = (state_q == StApply) && cmd_illegal;

  always_comb begin
    ready_d = ready_q;
    prio_d  = prio_q;
    tcb_d   = tcb_q;
    if ((state_q == StApply) && !cmd_illegal) begin
      unique case (cmd_op_q)
        OpReady: begin
          ready_d[cmd_idx] = 1'b1;
          prio_d[cmd_idx]  = cmd_prio_q[PW-1:0];
        end
        OpBlock:  ready_d[cmd_idx] = 1'b0;
        OpSettcb: tcb_d[cmd_idx]   = cmd_data_q;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StApply;
        end else if (addrread_in != cur_q) begin
          state_d = StScan;
          cnt_d   = '0;
          cur_d   = addrread_in;
        end
      end
      StApply: begin
        state_d = StScan;
        cnt_d   = '0;
        cur_d   = addrread_in;
      end
      StScan: begin
        if (cnt_q == TW'(NUM_TASKS - 1)) begin
          state_d = StPublish;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      StPublish: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cur_q   <= IDLE_TASK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_op_q   <= OpNop;
      cmd_task_q <= '0;
      cmd_prio_q <= '0;
      cmd_data_q <= '0;
    end else if (accept) begin
      cmd_op_q   <= cmd_op_e'(cmd_op);
      cmd_task_q <= cmd_task;
      cmd_prio_q <= cmd_prio;
      cmd_data_q <= cmd_data;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_q           <= '0;
      ready_q[IDLE_IDX] <= 1'b1;
      prio_q            <= '0;
      tcb_q             <= '0;
    end else begin
      ready_q <= ready_d;
      prio_q  <= prio_d;
      tcb_q   <= tcb_d;
    end
  end

  always_comb begin
    cur_in_range = 32'(cur_q) < NUM_TASKS;
    cur_idx      = cur_in_range ? cur_q[TW-1:0] : '0;
    cur_valid    = cur_in_range && ready_q[cur_idx];
    rd_in_range  = 32'(addrread_in) < NUM_TASKS;
    rd_idx       = rd_in_range ? addrread_in[TW-1:0] : '0;
    tcbtask_out  = rd_in_range ? tcb_q[rd_idx] : 32'd0;
  end

  readylist_scan #(
    .NUM_TASKS (NUM_TASKS),
    .NUM_PRIO  (NUM_PRIO)
  ) u_scan (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .visit      (state_q == StScan),
    .idx        (cnt_q),
    .task_ready (ready_q[cnt_q]),
    .task_prio  (prio_q[cnt_q]),
    .cur_task   (cur_q),
    .cur_valid  (cur_valid),
    .cur_prio   (prio_q[cur_idx]),
    .best_prio  (scan_best_prio),
    .best_task  (scan_best_task),
    .next_task  (scan_next_task)
  );

  // All three results change together, only at the end of a complete scan.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hp_q  <= '0;
      hpt_q <= '0;
      nxt_q <= '0;
    end else if (state_q == StPublish) begin
      hp_q  <= 6'(scan_best_prio);
      hpt_q <= 8'(scan_best_task);
      nxt_q <= scan_next_task;
    end
  end

  assign highpriority_out = hp_q;
  assign ptr_hpritask_out = hpt_q;
  assign ptr_nexttask_out = nxt_q;

endmodule

// File: tb/tb_ready_list.sv
// Scoreboard bench for ready_list: directed commands push expected results,
// a monitor compares them each time the block returns to idle after a publish.
module tb_ready_list;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_task;
  logic [5:0]  cmd_prio;
  logic [31:0] cmd_data;
  logic [7:0]  addrread_in;
  logic [5:0]  highpriority_out;
  logic [7:0]  ptr_hpritask_out;
  logic [7:0]  ptr_nexttask_out;
  logic [31:0] tcbtask_out;
  logic        err_out;

  localparam logic [1:0] NOP = 2'b00, RDY = 2'b01, BLK = 2'b10, TCB = 2'b11;

  ready_list dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_task         (cmd_task),
    .cmd_prio         (cmd_prio),
    .cmd_data         (cmd_data),
    .addrread_in      (addrread_in),
    .highpriority_out (highpriority_out),
    .ptr_hpritask_out (ptr_hpritask_out),
    .ptr_nexttask_out (ptr_nexttask_out),
    .tcbtask_out      (tcbtask_out),
    .err_out          (err_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    string       name;
    logic [5:0]  hp;
    logic [7:0]  hpt;
    logic [7:0]  nxt;
    logic [31:0] tcb;
    int          errs;
    int          busy;   // -1: not checked (event follows a reset)
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass = 0;
  int   n_total = 0;
  int   busy_cnt = 0;
  int   err_cnt = 0;
  logic prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a low-to-high cmd_ready transition marks freshly published outputs.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_ready = 1'b0;
      busy_cnt   = 0;
      err_cnt    = 0;
    end else begin
      if (err_out) err_cnt++;
      if (!cmd_ready) begin
        busy_cnt++;
      end else if (!prev_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_publish: got hp=%0d hpt=%0d, expected no event",
                   highpriority_out, ptr_hpritask_out);
        end else begin
          e = sb.pop_front();
          check({e.name, ".highprio"}, 32'(highpriority_out), 32'(e.hp));
          check({e.name, ".hpritask"}, 32'(ptr_hpritask_out), 32'(e.hpt));
          check({e.name, ".nexttask"}, 32'(ptr_nexttask_out), 32'(e.nxt));
          check({e.name, ".tcb"}, tcbtask_out, e.tcb);
          check({e.name, ".err_pulses"}, 32'(err_cnt), 32'(e.errs));
          if (e.busy >= 0) check({e.name, ".busy_cycles"}, 32'(busy_cnt), 32'(e.busy));
        end
        busy_cnt = 0;
        err_cnt  = 0;
      end
      prev_ready = cmd_ready;
    end
  end

  task automatic push(input string name, input int hp, input int hpt, input int nxt,
                      input logic [31:0] tcb, input int errs, input int busy);
    exp_t x;
    x.name = name; x.hp = 6'(hp); x.hpt = 8'(hpt); x.nxt = 8'(nxt);
    x.tcb = tcb; x.errs = errs; x.busy = busy;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (cmd_ready && (sb.size() == 0)) return;
    end
    n_total++;
    $display("FAIL wait_idle: got %0d pending events after 200 cycles, expected 0", sb.size());
    sb.delete();
  endtask

  task automatic drive_cmd(input logic [1:0] op, input int t, input int p,
                           input logic [31:0] d, input int addr);
    #1;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_task    = 8'(t);
    cmd_prio    = 6'(p);
    cmd_data    = d;
    addrread_in = 8'(addr);
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic step_cmd(input string name, input logic [1:0] op, input int t, input int p,
                          input logic [31:0] d, input int addr, input int hp, input int hpt,
                          input int nxt, input logic [31:0] tcb, input int errs);
    wait_idle();
    push(name, hp, hpt, nxt, tcb, errs, 18);
    drive_cmd(op, t, p, d, addr);
  endtask

  task automatic step_addr(input string name, input int addr, input int hp, input int hpt,
                           input int nxt, input logic [31:0] tcb);
    wait_idle();
    push(name, hp, hpt, nxt, tcb, 0, 17);
    #1 addrread_in = 8'(addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_task = '0;
    cmd_prio = '0; cmd_data = '0; addrread_in = '0;
    push("reset", 0, 0, 0, 32'h0, 0, -1);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    //        name            op   task prio data          addr hp hpt nxt tcb        err
    step_cmd("ready3p5",      RDY, 3,   5,   32'h0,        0,   5, 3,  0,  32'h0,     0);
    step_cmd("block3",        BLK, 3,   0,   32'h0,        0,   0, 0,  0,  32'h0,     0);
    step_cmd("ready2p4",      RDY, 2,   4,   32'h0,        0,   4, 2,  0,  32'h0,     0);
    step_cmd("ready5p4",      RDY, 5,   4,   32'h0,        0,   4, 2,  0,  32'h0,     0);
    step_cmd("ready9p4",      RDY, 9,   4,   32'h0,        0,   4, 2,  0,  32'h0,     0);
    step_addr("cur5", 5, 4, 2, 9, 32'h0);
    step_addr("cur9_wrap", 9, 4, 2, 2, 32'h0);
    step_addr("cur2", 2, 4, 2, 5, 32'h0);
    step_cmd("block_idle",    BLK, 0,   0,   32'h0,        2,   4, 2,  5,  32'h0,     1);
    step_cmd("ready_oob",     RDY, 20,  1,   32'h0,        2,   4, 2,  5,  32'h0,     1);
    step_cmd("prio_oob",      RDY, 4,   9,   32'h0,        2,   4, 2,  5,  32'h0,     1);
    step_cmd("nop",           NOP, 0,   0,   32'h0,        2,   4, 2,  5,  32'h0,     0);
    step_cmd("block_unready", BLK, 11,  0,   32'h0,        2,   4, 2,  5,  32'h0,     0);
    // Task 4 must still be unready, so next falls back to the best task.
    step_addr("cur4_unready", 4, 4, 2, 2, 32'h0);
    step_cmd("settcb7",       TCB, 7,   0,   32'h4000_1000, 7,  4, 2,  2,  32'h4000_1000, 0);
    step_addr("cur_oob", 30, 4, 2, 2, 32'h0);
    step_addr("cur7_tcb", 7, 4, 2, 2, 32'h4000_1000);
    step_cmd("tie_ready3p4",  RDY, 3,   4,   32'h0,        5,   4, 2,  9,  32'h0,     0);
    step_cmd("reprio9p6",     RDY, 9,   6,   32'h0,        5,   6, 9,  2,  32'h0,     0);

    // Reset in the middle of a scan: the pending READY must never publish.
    wait_idle();
    drive_cmd(RDY, 6, 7, 32'h0, 5);
    repeat (9) @(posedge aclk);
    #1;
    push("midscan_reset", 0, 0, 0, 32'h0, 0, -1);
    aresetn = 1'b0;
    addrread_in = 8'd0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;

    step_cmd("post_rst_ready1", RDY, 1, 1,   32'h0,        0,   1, 1,  0,  32'h0,     0);
    step_addr("post_rst_cur7", 7, 1, 1, 1, 32'h0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
